// File: rtl/man_tx_sched.sv
// man_tx_sched: round-robin frame scheduler in front of the NRZ-to-Manchester
// encoder. Grants one requester per frame and serialises preamble, start bit,
// MSB-first data and even parity, holding each NRZ bit for two half-bit clocks,
// followed by an idle inter-frame gap.
module man_tx_sched #(
  parameter int DATA_W   = 8,
  parameter int PRE_LEN  = 4,
  parameter int NREQ     = 2,
  parameter int GAP_BITS = 2,
  localparam int GID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     nrz_out,
  output logic                     enc_en,
  output logic                     phase,
  output logic                     busy,
  output logic [GID_W-1:0]         grant_id,
  output logic [2:0]               state
);

  // One counter serves preamble bits, data bits and gap clocks.
  localparam int MAX_A   = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int CNT_MAX = (MAX_A > GAP_BITS * 2) ? MAX_A : GAP_BITS * 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t              state_r;
  logic                nrz_r;
  logic                enc_r;
  logic                phase_r;
  logic                busy_r;
  logic [GID_W-1:0]    grant_r;
  logic [GID_W-1:0]    last_grant_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   shift_r;
  logic                par_r;

  logic                found_s;
  logic [GID_W-1:0]    sel_s;
  logic [GID_W-1:0]    cand_s;
  logic [NREQ-1:0]     rdy_s;
  logic                accept_s;
  logic [DATA_W-1:0]   sel_word_s;

  // Even parity: XOR of all payload bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    cand_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = GID_W'((int'(last_grant_r) + k) % NREQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot ready, offered only in IDLE and never while reset is asserted.
  always_comb begin
    rdy_s = '0;
    if ((state_r == ST_IDLE) && !reset && found_s) begin
      rdy_s[sel_s] = 1'b1;
    end else begin
      rdy_s = '0;
    end
  end

  assign req_ready  = rdy_s;
  assign accept_s   = |(rdy_s & req_valid);
  assign sel_word_s = req_data[int'(sel_s) * DATA_W +: DATA_W];

  // Frame FSM: accept, then preamble/start/data/parity at two clocks per bit, then gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      nrz_r        <= 1'b0;
      enc_r        <= 1'b0;
      phase_r      <= 1'b0;
      busy_r       <= 1'b0;
      grant_r      <= '0;
      last_grant_r <= GID_W'(NREQ - 1);
      cnt_r        <= '0;
      shift_r      <= '0;
      par_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= '0;
          phase_r <= 1'b0;
          if (accept_s) begin
            shift_r      <= sel_word_s;
            par_r        <= even_parity(sel_word_s);
            grant_r      <= sel_s;
            last_grant_r <= sel_s;
            state_r      <= ST_PRE;
            nrz_r        <= 1'b1;
            enc_r        <= 1'b1;
            busy_r       <= 1'b1;
          end else begin
            nrz_r  <= 1'b0;
            enc_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        ST_PRE: begin
          phase_r <= ~phase_r;
          if (phase_r) begin
            if (cnt_r == CNT_W'(PRE_LEN - 1)) begin
              state_r <= ST_START;
              nrz_r   <= 1'b1;
              cnt_r   <= '0;
            end else begin
              // Next preamble index is cnt_r+1; odd indices carry 0.
              cnt_r <= cnt_r + CNT_W'(1);
              nrz_r <= cnt_r[0];
            end
          end
        end
        ST_START: begin
          phase_r <= ~phase_r;
          if (phase_r) begin
            state_r <= ST_DATA;
            nrz_r   <= shift_r[DATA_W-1];
            shift_r <= {shift_r[DATA_W-2:0], 1'b0};
            cnt_r   <= '0;
          end
        end
        ST_DATA: begin
          phase_r <= ~phase_r;
          if (phase_r) begin
            if (cnt_r == CNT_W'(DATA_W - 1)) begin
              state_r <= ST_PAR;
              nrz_r   <= par_r;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
              nrz_r   <= shift_r[DATA_W-1];
              shift_r <= {shift_r[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_PAR: begin
          phase_r <= ~phase_r;
          if (phase_r) begin
            state_r <= ST_GAP;
            enc_r   <= 1'b0;
            nrz_r   <= 1'b0;
            phase_r <= 1'b0;
            cnt_r   <= '0;
          end
        end
        ST_GAP: begin
          enc_r   <= 1'b0;
          nrz_r   <= 1'b0;
          phase_r <= 1'b0;
          if (cnt_r == CNT_W'(GAP_BITS * 2 - 1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          // Unreachable encodings recover to IDLE; grant history is kept.
          state_r <= ST_IDLE;
          nrz_r   <= 1'b0;
          enc_r   <= 1'b0;
          phase_r <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign nrz_out  = nrz_r;
  assign enc_en   = enc_r;
  assign phase    = phase_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;
  assign state    = state_r;

endmodule

// File: tb/tb_man_tx_sched.sv
// tb_man_tx_sched: random and directed stimulus against a cycle-position model
// of the framed NRZ stream (frame built as a bit list, indexed by clocks since accept).
module tb_man_tx_sched;

  localparam int DATA_W    = 8;
  localparam int PRE_LEN   = 4;
  localparam int NREQ      = 2;
  localparam int GAP_BITS  = 2;
  localparam int GID_W     = 1;
  localparam int NBITS     = PRE_LEN + 1 + DATA_W + 1;
  localparam int FRAME_CYC = NBITS * 2;
  localparam int TOTAL_CYC = FRAME_CYC + GAP_BITS * 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   nrz_out;
  logic                   enc_en;
  logic                   phase;
  logic                   busy;
  logic [GID_W-1:0]       grant_id;
  logic [2:0]             state;

  always #5 clk = ~clk;

  man_tx_sched #(
    .DATA_W(DATA_W), .PRE_LEN(PRE_LEN), .NREQ(NREQ), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .nrz_out(nrz_out), .enc_en(enc_en), .phase(phase),
    .busy(busy), .grant_id(grant_id), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int   m_pos;            // 0 = idle, 1..TOTAL_CYC = clocks since accept
  int   m_ptr;            // last granted requester
  int   m_gid;
  logic m_bits [NBITS];

  // observations from the most recent step
  int              cyc = 0;
  logic [NREQ-1:0] last_rdy;
  logic [2:0]      last_state;
  logic            last_enc, last_nrz, last_busy;
  int              enc_hi_cnt, busy_cnt;
  int              acc_cyc [$];
  logic [NREQ-1:0] acc_rdy [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester after the last grant, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic rst, input logic [NREQ-1:0] v, input logic [NREQ*DATA_W-1:0] d);
    int sel;
    int b;
    logic [DATA_W-1:0] w;
    logic [NREQ-1:0] e_rdy;
    logic [2:0] e_state;
    logic e_enc, e_nrz, e_phase, e_busy;
    @(negedge clk);
    reset = rst;
    req_valid = v;
    req_data = d;
    #1;
    sel = pick(v, m_ptr);
    e_rdy = '0; e_state = 3'd0; e_enc = 1'b0; e_nrz = 1'b0; e_phase = 1'b0; e_busy = 1'b0;
    if (m_pos == 0) begin
      if (!rst && sel >= 0) e_rdy = NREQ'(1) << sel;
    end else if (m_pos <= FRAME_CYC) begin
      b = (m_pos - 1) / 2;
      e_enc = 1'b1;
      e_busy = 1'b1;
      e_phase = ((m_pos - 1) % 2) == 1;
      e_nrz = m_bits[b];
      if (b < PRE_LEN) e_state = 3'd1;
      else if (b == PRE_LEN) e_state = 3'd2;
      else if (b <= PRE_LEN + DATA_W) e_state = 3'd3;
      else e_state = 3'd4;
    end else begin
      e_busy = 1'b1;
      e_state = 3'd5;
    end
    check("req_ready", req_ready, e_rdy);
    check("state", state, e_state);
    check("enc_en", enc_en, e_enc);
    check("nrz_out", nrz_out, e_nrz);
    check("phase", phase, e_phase);
    check("busy", busy, e_busy);
    check("grant_id", grant_id, m_gid);
    last_rdy = req_ready; last_state = state; last_enc = enc_en;
    last_nrz = nrz_out; last_busy = busy;
    if (enc_en === 1'b1) enc_hi_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if ((req_ready & v) != '0) begin
      acc_cyc.push_back(cyc);
      acc_rdy.push_back(req_ready);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pos = 0; m_ptr = NREQ - 1; m_gid = 0;
    end else if (m_pos == 0) begin
      if (sel >= 0) begin
        w = d[sel*DATA_W +: DATA_W];
        for (int i = 0; i < PRE_LEN; i++) m_bits[i] = (i % 2) == 0;
        m_bits[PRE_LEN] = 1'b1;
        for (int j = 0; j < DATA_W; j++) m_bits[PRE_LEN + 1 + j] = w[DATA_W - 1 - j];
        m_bits[NBITS - 1] = ($countones(w) % 2) == 1;
        m_pos = 1; m_ptr = sel; m_gid = sel;
      end
    end else if (m_pos == TOTAL_CYC) begin
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endtask

  // Offer a word on requester 0 until accepted, then scramble inputs for the rest of the frame.
  task automatic send_one(input logic [DATA_W-1:0] word);
    int guard;
    logic [NREQ*DATA_W-1:0] d;
    guard = 0;
    enc_hi_cnt = 0;
    busy_cnt = 0;
    while (m_pos == 0 && guard < 10) begin
      d = NREQ*DATA_W'($urandom);
      d[DATA_W-1:0] = word;
      step(1'b0, NREQ'(1), d);
      guard++;
    end
    check("accept_seen", m_pos != 0, 1);
    while (m_pos != 0 && guard < 100) begin
      step(1'b0, NREQ'($urandom), NREQ*DATA_W'($urandom));
      guard++;
    end
    check("frame_end_seen", m_pos == 0, 1);
    check("enc_cycles", enc_hi_cnt, FRAME_CYC);
    check("busy_cycles", busy_cnt, TOTAL_CYC);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    m_pos = 0; m_ptr = NREQ - 1; m_gid = 0;
    repeat (2) @(posedge clk);

    // reset state and idle stability
    for (int i = 0; i < 50; i++) step(1'b0, '0, NREQ*DATA_W'($urandom));

    // single frames: pattern and parity corners
    send_one(8'hA5);
    send_one(8'h01);
    send_one(8'hFF);
    send_one(8'h00);

    // contention: both requesters valid continuously
    acc_cyc.delete();
    acc_rdy.delete();
    step(1'b1, '0, '0);
    for (int i = 0; i < 70; i++) step(1'b0, 2'b11, 16'h2211);
    check("cont_count", acc_cyc.size(), 3);
    if (acc_cyc.size() >= 3) begin
      check("cont_g0", acc_rdy[0], 2'b01);
      check("cont_g1", acc_rdy[1], 2'b10);
      check("cont_g2", acc_rdy[2], 2'b01);
      check("cont_period1", acc_cyc[1] - acc_cyc[0], 33);
      check("cont_period2", acc_cyc[2] - acc_cyc[1], 33);
    end
    guard = 0;
    while (m_pos != 0 && guard < 50) begin
      step(1'b0, '0, '0);
      guard++;
    end

    // mid-frame abort during DATA, requester 0 keeps valid high
    guard = 0;
    while (m_pos == 0 && guard < 10) begin
      step(1'b0, 2'b01, 16'h00C3);
      guard++;
    end
    while (m_pos < 14 && guard < 40) begin
      step(1'b0, 2'b01, 16'h00C3);
      guard++;
    end
    check("abort_in_data", last_state, 3'd3);
    step(1'b1, 2'b01, 16'h00C3);
    step(1'b0, 2'b01, 16'h00C3);
    check("abort_state", last_state, 3'd0);
    check("abort_enc", last_enc, 1'b0);
    check("abort_nrz", last_nrz, 1'b0);
    check("abort_busy", last_busy, 1'b0);
    check("abort_rdy", last_rdy, 2'b01);
    guard = 0;
    while (m_pos != 0 && guard < 50) begin
      step(1'b0, '0, NREQ*DATA_W'($urandom));
      guard++;
    end

    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 299) == 0, NREQ'($urandom & $urandom), NREQ*DATA_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
